// File: rtl/obi_d_arbiter.sv
// Two-master round-robin OBI data arbiter with transaction lock and in-order response routing.
// Define OBI_ARB_STATS_EN to add saturating grant and contention counters.
module obi_d_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          WRITE_RVALID    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_be_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_be_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,

`ifdef OBI_ARB_STATS_EN
  output logic [15:0] m0_grant_cnt_o,
  output logic [15:0] m1_grant_cnt_o,
  output logic [15:0] contention_cnt_o,
`endif
  output logic        err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  logic             rr_q, rr_d;
  logic             lock_q, lock_d;
  logic             lock_id_q, lock_id_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_id_q [MAX_OUTSTANDING];
  logic             fifo_id_d [MAX_OUTSTANDING];
  logic             fifo_we_q [MAX_OUTSTANDING];
  logic             fifo_we_d [MAX_OUTSTANDING];
  logic             m0_rvalid_q, m0_rvalid_d;
  logic             m1_rvalid_q, m1_rvalid_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d;
  logic [31:0]      m1_rdata_q, m1_rdata_d;
  logic             err_q, err_d;

  logic             sel;
  logic             sel_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             hs;
  logic             drop_err;
  logic             rsp_err;
  logic             pop;
  logic [31:0]      rsp_data;
  logic             head_id;
  logic             head_we;

  // Master selection: a locked master keeps the port, otherwise round-robin on contention.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_id_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end else if (m0_req_i && m1_req_i) begin
      sel = ~rr_q;
    end else begin
      sel = 1'b0;
    end
  end

  assign sel_req    = sel ? m1_req_i : m0_req_i;
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == {CNT_W{1'b0}});
  assign hs         = s_req_o && s_gnt_i;

  assign s_req_o   = sel_req && !fifo_full;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign m0_gnt_o  = !sel && s_req_o && s_gnt_i;
  assign m1_gnt_o  = sel && s_req_o && s_gnt_i;

  // Lock tracking and round-robin pointer update.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    drop_err  = 1'b0;
    rr_d      = rr_q;
    if (hs) begin
      lock_d = 1'b0;
      rr_d   = sel;
    end else if (s_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end else if (lock_q && !sel_req) begin
      lock_d   = 1'b0;
      drop_err = 1'b1;
    end else begin
      lock_d = lock_q;
    end
  end

  assign head_id = fifo_id_q[rd_ptr_q];
  assign head_we = fifo_we_q[rd_ptr_q];

  // Response side: synthesised write responses pop without waiting for the slave.
  always_comb begin
    pop      = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = 32'h0000_0000;
    if (fifo_empty) begin
      rsp_err = s_rvalid_i;
    end else if (head_we && !WRITE_RVALID) begin
      pop     = 1'b1;
      rsp_err = s_rvalid_i;
    end else if (s_rvalid_i) begin
      pop      = 1'b1;
      rsp_data = s_rdata_i;
    end else begin
      pop = 1'b0;
    end
  end

  // Next-state for the response registers and the tracker FIFO.
  always_comb begin
    m0_rvalid_d = pop && !head_id;
    m1_rvalid_d = pop && head_id;
    m0_rdata_d  = (pop && !head_id) ? rsp_data : m0_rdata_q;
    m1_rdata_d  = (pop && head_id) ? rsp_data : m1_rdata_q;
    err_d       = drop_err || rsp_err;
    fifo_id_d   = fifo_id_q;
    fifo_we_d   = fifo_we_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (hs) begin
      fifo_id_d[wr_ptr_q] = sel;
      fifo_we_d[wr_ptr_q] = s_we_o;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({hs, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0000_0000;
      m1_rdata_q  <= 32'h0000_0000;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        fifo_id_q[i] <= 1'b0;
        fifo_we_q[i] <= 1'b0;
      end
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      err_q       <= err_d;
      fifo_id_q   <= fifo_id_d;
      fifo_we_q   <= fifo_we_d;
    end
  end

  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;
  assign err_o       = err_q;

`ifdef OBI_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) begin
      sat_inc = v + 16'd1;
    end else begin
      sat_inc = v;
    end
  endfunction

  logic [15:0] m0_grant_cnt_q, m0_grant_cnt_d;
  logic [15:0] m1_grant_cnt_q, m1_grant_cnt_d;
  logic [15:0] contention_cnt_q, contention_cnt_d;
  logic        contention;

  // Contention covers both masters asking, or the selected request held off by full/lock.
  always_comb begin
    contention       = (m0_req_i && m1_req_i) || (sel_req && (fifo_full || lock_q));
    m0_grant_cnt_d   = sat_inc(m0_grant_cnt_q, m0_gnt_o);
    m1_grant_cnt_d   = sat_inc(m1_grant_cnt_q, m1_gnt_o);
    contention_cnt_d = sat_inc(contention_cnt_q, contention);
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m0_grant_cnt_q   <= 16'h0000;
      m1_grant_cnt_q   <= 16'h0000;
      contention_cnt_q <= 16'h0000;
    end else begin
      m0_grant_cnt_q   <= m0_grant_cnt_d;
      m1_grant_cnt_q   <= m1_grant_cnt_d;
      contention_cnt_q <= contention_cnt_d;
    end
  end

  assign m0_grant_cnt_o   = m0_grant_cnt_q;
  assign m1_grant_cnt_o   = m1_grant_cnt_q;
  assign contention_cnt_o = contention_cnt_q;
`endif

endmodule

// File: tb/tb_obi_d_arbiter.sv
// Self-checking bench for obi_d_arbiter: vector table, directed corner sequences and
// randomized traffic checked every cycle against a queue-based transaction model.
module tb_obi_d_arbiter;

  localparam int MAXO = 2;
  localparam bit WRV  = 1'b0;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;
  logic        err_o;
`ifdef OBI_ARB_STATS_EN
  logic [15:0] m0_grant_cnt_o, m1_grant_cnt_o, contention_cnt_o;
`endif

  obi_d_arbiter #(.MAX_OUTSTANDING(MAXO), .WRITE_RVALID(WRV)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_be_i(m0_be_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_be_i(m1_be_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_be_o(s_be_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
`ifdef OBI_ARB_STATS_EN
    .m0_grant_cnt_o(m0_grant_cnt_o), .m1_grant_cnt_o(m1_grant_cnt_o),
    .contention_cnt_o(contention_cnt_o),
`endif
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model: outstanding transactions kept in issue order.
  typedef struct packed { logic id; logic we; } ent_t;
  ent_t        q[$];
  ent_t        ent;
  logic        m_rr = 1'b0, m_lock = 1'b0, m_lid = 1'b0;
  logic        m_rv0 = 1'b0, m_rv1 = 1'b0, m_err = 1'b0;
  logic [31:0] m_rd0 = 32'h0, m_rd1 = 32'h0;
  logic        e_sel, e_selreq, e_sreq, e_hs, n_err, n_rv0, n_rv1;
  int          m_gc0 = 0, m_gc1 = 0, m_cc = 0;

  task automatic deliver(input logic id, input logic [31:0] d);
    if (id) begin n_rv1 = 1'b1; m_rd1 = d; end
    else begin n_rv0 = 1'b1; m_rd0 = d; end
  endtask

  task automatic mdl_step();
    if (m_lock) e_sel = m_lid;
    else if (m0_req_i != m1_req_i) e_sel = m1_req_i;
    else e_sel = !m_rr;
    e_selreq = e_sel ? m1_req_i : m0_req_i;
    e_sreq   = e_selreq && (q.size() < MAXO);
    e_hs     = e_sreq && s_gnt_i;
    check1("s_req_o", s_req_o, e_sreq);
    check1("m0_gnt_o", m0_gnt_o, e_hs && !e_sel);
    check1("m1_gnt_o", m1_gnt_o, e_hs && e_sel);
    if (e_sreq) begin
      check32("s_addr_o", s_addr_o, e_sel ? m1_addr_i : m0_addr_i);
      check32("s_wdata_o", s_wdata_o, e_sel ? m1_wdata_i : m0_wdata_i);
      check1("s_we_o", s_we_o, e_sel ? m1_we_i : m0_we_i);
      check32("s_be_o", {28'h0, s_be_o}, {28'h0, e_sel ? m1_be_i : m0_be_i});
    end
    check1("m0_rvalid_o", m0_rvalid_o, m_rv0);
    check1("m1_rvalid_o", m1_rvalid_o, m_rv1);
    check32("m0_rdata_o", m0_rdata_o, m_rd0);
    check32("m1_rdata_o", m1_rdata_o, m_rd1);
    check1("err_o", err_o, m_err);
`ifdef OBI_ARB_STATS_EN
    check32("m0_grant_cnt", {16'h0, m0_grant_cnt_o}, m_gc0);
    check32("m1_grant_cnt", {16'h0, m1_grant_cnt_o}, m_gc1);
    check32("contention_cnt", {16'h0, contention_cnt_o}, m_cc);
`endif
    if (rst_i) begin
      q.delete();
      m_rr = 1'b0; m_lock = 1'b0; m_lid = 1'b0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = 32'h0; m_rd1 = 32'h0; m_err = 1'b0;
      m_gc0 = 0; m_gc1 = 0; m_cc = 0;
    end else begin
      n_err = 1'b0; n_rv0 = 1'b0; n_rv1 = 1'b0;
      if (((m0_req_i && m1_req_i) || (e_selreq && (q.size() >= MAXO || m_lock))) && m_cc < 65535)
        m_cc++;
      if (m_lock && !e_selreq) begin n_err = 1'b1; m_lock = 1'b0; end
      else if (e_hs) m_lock = 1'b0;
      else if (e_sreq) begin m_lock = 1'b1; m_lid = e_sel; end
      if (q.size() == 0) begin
        if (s_rvalid_i) n_err = 1'b1;
      end else if (q[0].we && !WRV) begin
        deliver(q[0].id, 32'h0);
        if (s_rvalid_i) n_err = 1'b1;
        void'(q.pop_front());
      end else if (s_rvalid_i) begin
        deliver(q[0].id, s_rdata_i);
        void'(q.pop_front());
      end
      if (e_hs) begin
        ent.id = e_sel;
        ent.we = e_sel ? m1_we_i : m0_we_i;
        q.push_back(ent);
        m_rr = e_sel;
        if (!e_sel && m_gc0 < 65535) m_gc0++;
        if (e_sel && m_gc1 < 65535) m_gc1++;
      end
      m_rv0 = n_rv0; m_rv1 = n_rv1; m_err = n_err;
    end
  endtask

  logic g0, g1;
  task automatic smp();
    @(negedge clk);
    mdl_step();
    g0 = m0_gnt_o;
    g1 = m1_gnt_o;
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = 32'h0; m0_wdata_i = 32'h0; m0_be_i = 4'hF;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = 32'h0; m1_wdata_i = 32'h0; m1_be_i = 4'hF;
    s_gnt_i = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    smp(); adv();
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic m0_req, m1_req, s_rvalid;
    logic [31:0] rdata;
    logic e_g0, e_g1, e_rv0, e_rv1;
    logic [31:0] e_rdata;
  } vec_t;
  vec_t vt[10];

  initial begin
    // Both masters read every cycle for 8 cycles, slave answers one cycle after grant.
    vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[2] = '{1'b1, 1'b1, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0001};
    vt[3] = '{1'b1, 1'b1, 1'b1, 32'hA000_0003, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA000_0002};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'hA000_0004, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0003};
    vt[5] = '{1'b1, 1'b1, 1'b1, 32'hA000_0005, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA000_0004};
    vt[6] = '{1'b1, 1'b1, 1'b1, 32'hA000_0006, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0005};
    vt[7] = '{1'b1, 1'b1, 1'b1, 32'hA000_0007, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA000_0006};
    vt[8] = '{1'b0, 1'b0, 1'b1, 32'hA000_0008, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0007};
    vt[9] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hA000_0008};

    idle();
    rst_i = 1'b1;
    smp(); adv();
    rst_i = 1'b0;

    // Reset state
    smp();
    check1("rst m0_rvalid", m0_rvalid_o, 1'b0);
    check1("rst m1_rvalid", m1_rvalid_o, 1'b0);
    check32("rst m0_rdata", m0_rdata_o, 32'h0);
    check32("rst m1_rdata", m1_rdata_o, 32'h0);
    check1("rst err", err_o, 1'b0);
    check1("rst s_req", s_req_o, 1'b0);
    adv();

    // Single read, one-cycle slave latency
    m0_req_i = 1'b1; m0_addr_i = 32'h8000_0010;
    smp();
    check1("t1 m0_gnt", m0_gnt_o, 1'b1);
    check32("t1 s_addr", s_addr_o, 32'h8000_0010);
    adv();
    m0_req_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h1234_5678;
    smp();
    check1("t1 early rvalid", m0_rvalid_o, 1'b0);
    adv();
    s_rvalid_i = 1'b0;
    smp();
    check1("t1 m0_rvalid", m0_rvalid_o, 1'b1);
    check32("t1 m0_rdata", m0_rdata_o, 32'h1234_5678);
    check1("t1 m1_rvalid", m1_rvalid_o, 1'b0);
    adv();
    smp();
    check1("t1 rvalid pulse", m0_rvalid_o, 1'b0);
    check32("t1 rdata hold", m0_rdata_o, 32'h1234_5678);
    adv();

    // Vector table: round-robin alternation and in-order routing
    do_reset();
    m0_addr_i = 32'h0000_0100; m1_addr_i = 32'h0000_0200;
    for (int k = 0; k < 10; k++) begin
      m0_req_i = vt[k].m0_req; m1_req_i = vt[k].m1_req;
      s_gnt_i = 1'b1; s_rvalid_i = vt[k].s_rvalid; s_rdata_i = vt[k].rdata;
      smp();
      check1($sformatf("vec%0d m0_gnt", k), m0_gnt_o, vt[k].e_g0);
      check1($sformatf("vec%0d m1_gnt", k), m1_gnt_o, vt[k].e_g1);
      check1($sformatf("vec%0d m0_rvalid", k), m0_rvalid_o, vt[k].e_rv0);
      check1($sformatf("vec%0d m1_rvalid", k), m1_rvalid_o, vt[k].e_rv1);
      if (vt[k].e_rv0) check32($sformatf("vec%0d m0_rdata", k), m0_rdata_o, vt[k].e_rdata);
      if (vt[k].e_rv1) check32($sformatf("vec%0d m1_rdata", k), m1_rdata_o, vt[k].e_rdata);
      adv();
    end

    // Locally synthesised write response followed by a read
    do_reset();
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h8000_0004; m1_be_i = 4'b0011;
    m1_wdata_i = 32'h5555_AAAA;
    smp();
    check1("t3 m1_gnt", m1_gnt_o, 1'b1);
    check32("t3 s_be", {28'h0, s_be_o}, 32'h3);
    adv();
    m1_req_i = 1'b0; m0_req_i = 1'b1; m0_addr_i = 32'h8000_0020;
    smp();
    check1("t3 m0_gnt", m0_gnt_o, 1'b1);
    adv();
    m0_req_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE_F00D;
    smp();
    check1("t3 m1_rvalid", m1_rvalid_o, 1'b1);
    check32("t3 m1_rdata", m1_rdata_o, 32'h0);
    adv();
    s_rvalid_i = 1'b0;
    smp();
    check1("t3 m0_rvalid", m0_rvalid_o, 1'b1);
    check32("t3 m0_rdata", m0_rdata_o, 32'hCAFE_F00D);
    check1("t3 err", err_o, 1'b0);
    adv();

    // FIFO full with a slow slave: third read waits for the first pop
    do_reset();
    for (int c = 0; c < 14; c++) begin
      m0_req_i = (c <= 6);
      m0_addr_i = (c == 0) ? 32'h0000_1000 : ((c == 1) ? 32'h0000_1004 : 32'h0000_1008);
      s_rvalid_i = (c == 5) || (c == 6) || (c == 11);
      s_rdata_i = 32'hD000_0000 + 32'(c);
      smp();
      check1($sformatf("t4 c%0d s_req", c), s_req_o, (c <= 1) || (c == 6));
      check1($sformatf("t4 c%0d m0_gnt", c), m0_gnt_o, (c <= 1) || (c == 6));
      check1($sformatf("t4 c%0d m0_rvalid", c), m0_rvalid_o, (c == 6) || (c == 7) || (c == 12));
      if ((c == 6) || (c == 7) || (c == 12))
        check32($sformatf("t4 c%0d m0_rdata", c), m0_rdata_o, 32'hD000_0000 + 32'(c - 1));
      adv();
    end
    idle();

    // Slave stalls an m0 request while m1 competes
    do_reset();
    m0_addr_i = 32'h0000_00A0; m1_addr_i = 32'h0000_00B0;
    for (int c = 0; c < 7; c++) begin
      m0_req_i = (c <= 3);
      m1_req_i = (c >= 1) && (c <= 4);
      s_gnt_i = (c >= 3);
      s_rvalid_i = (c == 4) || (c == 5);
      s_rdata_i = 32'hE000_0000 + 32'(c);
      smp();
      if (c <= 3) begin
        check32($sformatf("t5 c%0d s_addr", c), s_addr_o, 32'h0000_00A0);
        check1($sformatf("t5 c%0d m1_gnt", c), m1_gnt_o, 1'b0);
        check1($sformatf("t5 c%0d m0_gnt", c), m0_gnt_o, c == 3);
      end
      if (c == 4) begin
        check1("t5 m1_gnt after", m1_gnt_o, 1'b1);
        check32("t5 s_addr m1", s_addr_o, 32'h0000_00B0);
      end
      adv();
    end
    idle();

    // Spurious rvalid, then reset with two reads outstanding
    do_reset();
    s_rvalid_i = 1'b1;
    smp(); adv();
    s_rvalid_i = 1'b0;
    smp();
    check1("t6 err pulse", err_o, 1'b1);
    adv();
    smp();
    check1("t6 err one cycle", err_o, 1'b0);
    adv();
    m0_req_i = 1'b1;
    smp(); adv();
    m0_req_i = 1'b0; m1_req_i = 1'b1;
    smp(); adv();
    m1_req_i = 1'b0; rst_i = 1'b1;
    smp(); adv();
    rst_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h7777_7777;
    smp(); adv();
    s_rvalid_i = 1'b0;
    smp();
    check1("t6 late err", err_o, 1'b1);
    check1("t6 late m0_rvalid", m0_rvalid_o, 1'b0);
    check1("t6 late m1_rvalid", m1_rvalid_o, 1'b0);
    adv();

    // Randomized traffic against the model
    do_reset();
    g0 = 1'b0; g1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!(m0_req_i && !g0 && $urandom_range(0, 19) != 0)) begin
        m0_req_i = ($urandom_range(0, 9) < 6);
        m0_we_i = 1'($urandom_range(0, 1));
        m0_addr_i = $urandom; m0_wdata_i = $urandom; m0_be_i = 4'($urandom);
      end
      if (!(m1_req_i && !g1 && $urandom_range(0, 19) != 0)) begin
        m1_req_i = ($urandom_range(0, 9) < 6);
        m1_we_i = 1'($urandom_range(0, 1));
        m1_addr_i = $urandom; m1_wdata_i = $urandom; m1_be_i = 4'($urandom);
      end
      s_gnt_i = ($urandom_range(0, 9) < 7);
      s_rvalid_i = (q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0);
      s_rdata_i = $urandom;
      rst_i = ($urandom_range(0, 149) == 0);
      smp();
      adv();
    end
    rst_i = 1'b0;
    idle();
    smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
